// File: rtl/ram_pkg.sv
// Shared types and the byte-lane merge used by the dual-port RAM.
// Merge works on a maximum-width word; callers zero-extend and truncate.
package ram_pkg;

  typedef enum logic {CLEAR, IDLE} ram_state_t;

  localparam int RAM_MAXW = 512;
  localparam int RAM_MAXB = RAM_MAXW / 8;

  function automatic logic [RAM_MAXW-1:0] ram_merge(
    input logic [RAM_MAXW-1:0] old_w,
    input logic [RAM_MAXW-1:0] new_w,
    input logic [RAM_MAXB-1:0] be
  );
    logic [RAM_MAXW-1:0] res;
    res = old_w;
    for (int i = 0; i < RAM_MAXB; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_clr_ctrl.sv
// Clear sequencer: walks every address once after reset or a clr pulse, 2**N cycles.
// Backpressure: busy stays high for the whole walk; clr is ignored while it runs.
module ram_clr_ctrl
  import ram_pkg::*;
#(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  output logic         busy,
  output logic         clr_en,
  output logic [N-1:0] clr_adr
);

  ram_state_t   state;
  logic [N-1:0] cnt;

  // N-bit counter with a terminal compare; it naturally returns to 0 on exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == {N{1'b1}}) state <= IDLE;
        end
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign busy    = (state == CLEAR);
  assign clr_en  = (state == CLEAR);
  assign clr_adr = cnt;

endmodule

// File: rtl/ram_2p_be.sv
// Simple dual-port RAM with byte enables, 1-cycle registered read, write-first forwarding.
// Backpressure: none except busy, during which user reads and writes are dropped.
module ram_2p_be
  import ram_pkg::*;
#(
  parameter int N = 6,
  parameter int M = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  output logic           busy,
  input  logic           we,
  input  logic [N-1:0]   wadr,
  input  logic [M/8-1:0] wbe,
  input  logic [M-1:0]   din,
  input  logic           re,
  input  logic [N-1:0]   radr,
  output logic [M-1:0]   dout,
  output logic           rvalid
);

  localparam int B = M / 8;

  if ((M % 8) != 0 || M > RAM_MAXW) begin : g_bad_width
    $error("ram_2p_be: M must be a multiple of 8 and at most RAM_MAXW");
  end

  logic [M-1:0] mem [2**N-1:0];

  logic         clr_en;
  logic [N-1:0] clr_adr;

  ram_clr_ctrl #(.N(N)) u_clr (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_adr (clr_adr)
  );

  logic         wr_en;
  logic [N-1:0] wr_adr;
  logic [B-1:0] wr_be;
  logic [M-1:0] wr_dat;

  // The clear walk owns the write port while it runs.
  always_comb begin
    wr_en  = we;
    wr_adr = wadr;
    wr_be  = wbe;
    wr_dat = din;
    if (clr_en) begin
      wr_en  = 1'b1;
      wr_adr = clr_adr;
      wr_be  = '1;
      wr_dat = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < B; i++) begin
        if (wr_be[i]) mem[wr_adr][8*i +: 8] <= wr_dat[8*i +: 8];
      end
    end
  end

  logic [M-1:0] fwd_word;
  assign fwd_word = M'(ram_merge(RAM_MAXW'(mem[radr]), RAM_MAXW'(din), RAM_MAXB'(wbe)));

  always_ff @(posedge clk) begin
    if (reset) begin
      dout   <= '0;
      rvalid <= 1'b0;
    end else if (busy) begin
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) dout <= (we && (wadr == radr)) ? fwd_word : mem[radr];
    end
  end

endmodule

// File: tb/tb_ram_2p_be.sv
// Scoreboard bench for ram_2p_be: a word-array model predicts reads and busy timing.
module tb_ram_2p_be;
  localparam int N = 4;
  localparam int M = 32;
  localparam int B = M / 8;
  localparam int D = 2**N;

  logic         clk = 1'b0;
  logic         reset, clr, we, re;
  logic [N-1:0] wadr, radr;
  logic [B-1:0] wbe;
  logic [M-1:0] din;
  logic         busy;
  logic [M-1:0] dout;
  logic         rvalid;

  always #5 clk = ~clk;

  ram_2p_be #(.N(N), .M(M)) dut (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .busy   (busy),
    .we     (we),
    .wadr   (wadr),
    .wbe    (wbe),
    .din    (din),
    .re     (re),
    .radr   (radr),
    .dout   (dout),
    .rvalid (rvalid)
  );

  int           errors = 0;
  int           checks = 0;
  logic [M-1:0] ref_mem [D];
  int           clr_left = 0;
  bit           exp_rvalid = 1'b0;
  bit           chk_en = 1'b0;
  logic [M-1:0] exp_q [$];

  task automatic check(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic zero_model();
    foreach (ref_mem[i]) ref_mem[i] = '0;
  endtask

  // Behavioural view of one clock edge: writes land before a same-cycle read sees the word.
  task automatic model_edge();
    if (reset) begin
      clr_left   = D;
      exp_rvalid = 1'b0;
      chk_en     = 1'b1;
      zero_model();
    end else if (clr_left > 0) begin
      clr_left--;
      exp_rvalid = 1'b0;
    end else begin
      if (we) begin
        for (int i = 0; i < B; i++)
          if (wbe[i]) ref_mem[wadr][8*i +: 8] = din[8*i +: 8];
      end
      exp_rvalid = re;
      if (re) exp_q.push_back(ref_mem[radr]);
      if (clr) begin
        clr_left = D;
        zero_model();
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet();
    reset = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  task automatic set_wr(input int a, input logic [M-1:0] d, input logic [B-1:0] be);
    we = 1'b1; wadr = N'(a); din = d; wbe = be;
  endtask

  task automatic set_rd(input int a);
    re = 1'b1; radr = N'(a);
  endtask

  // Monitor: every cycle compare busy/rvalid with the model, pop on each presented result.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", M'(busy), M'(clr_left > 0));
      check("rvalid", M'(rvalid), M'(exp_rvalid));
      if (rvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: dout %h with no read outstanding at %0t", dout, $time);
        end else begin
          check("dout", dout, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    quiet();
    wadr = '0; radr = '0; wbe = '0; din = '0;

    // Reset, then full clear walk and readback of every word.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_dout", dout, '0);
    check("rst_rvalid", M'(rvalid), '0);
    check("rst_busy", M'(busy), M'(1));
    repeat (D) step();
    for (int a = 0; a < D; a++) begin
      set_rd(a);
      step();
      check("clear_zero", dout, '0);
    end
    quiet();
    step();

    // Byte-enable merge.
    set_wr(3, 32'hAABBCCDD, 4'b1111);
    step();
    set_wr(3, 32'h11223344, 4'b0101);
    step();
    quiet();
    set_rd(3);
    step();
    re = 1'b0;
    check("be_merge", dout, 32'hAA22CC44);

    // Write-first collision on a zero word.
    set_wr(5, 32'hFFFFFFFF, 4'b0011);
    set_rd(5);
    step();
    quiet();
    check("collision", dout, 32'h0000FFFF);
    step();
    set_rd(5);
    step();
    re = 1'b0;
    check("collision_later", dout, 32'h0000FFFF);

    // User ops dropped while the clr-triggered walk runs.
    set_wr(2, 32'hCAFEBABE, 4'b1111);
    step();
    quiet();
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    set_wr(2, 32'h12345678, 4'b1111);
    set_rd(2);
    step();
    step();
    quiet();
    repeat (D - 3) step();
    set_rd(2);
    step();
    re = 1'b0;
    check("busy_drop", dout, '0);

    // Reset in the middle of a clear restarts the walk.
    for (int a = 0; a < D; a++) begin
      set_wr(a, 32'h5A000000 | M'(a), 4'b1111);
      step();
    end
    quiet();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midclr_busy", M'(busy), M'(1));
    repeat (D) step();
    for (int a = 0; a < D; a++) begin
      set_rd(a);
      step();
      check("midclr_zero", dout, '0);
    end
    quiet();
    step();

    // Back-to-back streaming.
    for (int a = 0; a < D; a++) begin
      set_wr(a, M'(a) * 32'h01010101, 4'b1111);
      step();
    end
    quiet();
    for (int a = 0; a < D; a++) begin
      set_rd(a);
      step();
      check("stream_dat", dout, M'(a) * 32'h01010101);
      check("stream_vld", M'(rvalid), M'(1));
    end
    quiet();
    step();

    // Random traffic with occasional clears.
    repeat (500) begin
      we   = 1'($urandom);
      re   = 1'($urandom);
      wadr = N'($urandom);
      radr = ($urandom_range(0, 3) == 0) ? wadr : N'($urandom);
      wbe  = B'($urandom);
      din  = $urandom;
      clr  = ($urandom_range(0, 79) == 0);
      step();
    end
    quiet();
    repeat (D + 4) step();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reads outstanding, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_2p_be.md
# ram_2p_be

Parametrised simple dual-port RAM: one write port with byte enables, one registered read port with valid flag, and write-first forwarding on address collision. A built-in clear sequencer zeroes every word after reset or on request. It replaces the single-port asynchronous-read RAM and stores register-file, cache-line and scratchpad data in the datapath. Depth is exactly 2**N words, with no fixed oversizing.

## Interface
Parameters:
- N, 6, address width; depth = 2**N words
- M, 32, data width in bits; must be a multiple of 8 (elaboration-time assertion); B = M/8 byte lanes

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; starts a clear sequence
- clr  in  1  one-cycle pulse; requests a clear sequence while idle
- busy  out  1  high while the clear sequence runs
- we  in  1  write enable
- wadr  in  N  write address
- wbe  in  B  byte enables; bit i controls din[8i+7:8i]
- din  in  M  write data
- re  in  1  read enable
- radr  in  N  read address
- dout  out  M  registered read data
- rvalid  out  1  high for one cycle when dout carries a new read result

## Operation
- States: CLEAR and IDLE.
  - reset → CLEAR, clear counter = 0.
  - CLEAR: each cycle writes 0 to mem[counter] and increments the counter. After address 2**N-1 is written → IDLE.
  - IDLE with clr=1 → CLEAR, counter = 0.
- clr is ignored while in CLEAR.
- reset asserted mid-clear restarts the sequence at address 0.
- busy = (state == CLEAR).
- While busy, we and re are ignored:
  - no user write reaches the array;
  - rvalid stays 0;
  - dout holds its value.
- Write (IDLE, we=1): for each lane i with wbe[i]=1, mem[wadr] lane i ← din lane i. Other lanes are unchanged. we=1 with wbe=0 changes nothing.
- Read (IDLE, re=1): dout ← mem[radr] and rvalid ← 1 on the next edge.
  - With re=0: rvalid ← 0 and dout holds.
- Collision (we=1, re=1, wadr==radr, same cycle): write-first.
  - Enabled lanes of dout come from din.
  - Disabled lanes come from the old stored word.
- Reset values: dout = 0, rvalid = 0, busy = 1 (from the first edge with reset high).
- Memory contents are not reset directly. They are zeroed by the clear sequence.

## Timing
- Read latency is 1 cycle: re sampled at edge t gives dout/rvalid valid after edge t.
- Reads and writes are fully pipelined, one of each per cycle. There is no back-pressure except busy.
- A write at edge t is visible to a read issued at edge t (via forwarding) and to any later read.
- Clear duration is exactly 2**N cycles after the last edge with reset high, or after the edge that samples clr.
  - busy falls on the edge that writes address 2**N-1.
  - User ops are accepted from the following cycle.
- Counter width is N+1 bits or an N-bit counter with a terminal flag. It must not wrap early at N.
- rvalid is never high in the cycle after an edge where busy was high.

## Structure
- Package ram_pkg:
  - typedef enum logic {CLEAR, IDLE} ram_state_t;
  - function for the byte-lane merge (old word, new word, enables).
- Sub-module ram_clr_ctrl: the state register, clear counter, busy output, and clear address/enable.
- The top level muxes the clear port and the user write port onto the array and implements the read register and forwarding.
- The array is a single unpacked logic [M-1:0] mem [2**N-1:0] written in one always_ff, so it infers block RAM.

## Test plan
- Reset and clear:
  - Stimulus: N=4, hold reset 1 cycle.
  - Required: busy high for 16 cycles, then low.
  - Then read addresses 0..15: every dout = 0, rvalid high 1 cycle after each re.
- Byte enables:
  - Stimulus: write 0xAABBCCDD to address 3 with wbe=4'b1111, then write 0x11223344 with wbe=4'b0101, then read address 3.
  - Required: dout = 0xAA22CC44.
- Collision:
  - Stimulus: mem[5] = 0x00000000; same cycle we=1, wbe=4'b0011, din=0xFFFFFFFF, re=1, radr=5.
  - Required: next cycle dout = 0x0000FFFF.
  - A later read of address 5 also returns 0x0000FFFF.
- Ops ignored while busy:
  - Stimulus: pulse clr, then during busy issue a write of 0x12345678 to address 2 and a read.
  - Required: rvalid stays 0; after busy falls, address 2 reads 0.
- Reset mid-clear:
  - Stimulus: assert reset at clear cycle 7 of 16.
  - Required: busy stays high for 16 more cycles from the reset edge, and all words read 0 afterwards.
- Back-to-back streaming:
  - Stimulus: write addresses 0..15 with data = address·0x01010101 on consecutive cycles, then read them on consecutive cycles.
  - Required: rvalid continuously high for 16 cycles with the matching data.
